// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: fetch PC, imem req/ack handshake, registered instr/pc to decode.
// Optional MISALIGN_TRAP_EN: a misaligned redirect traps instead of being force-aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_instr_valid,
    output logic        o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_TRAP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] r_instr;
    logic [31:0] w_instr_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_instr_valid;
    logic        w_instr_valid_next;
    logic        r_redir_pend;
    logic        w_redir_pend_next;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_next;
    logic        w_apply;
    logic [31:0] w_target;
`ifdef MISALIGN_TRAP_EN
    logic        r_misalign;
    logic        w_misalign_next;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_instr_next       = r_instr;
        w_pc_next          = r_pc;
        w_instr_valid_next = r_instr_valid;
        w_redir_pend_next  = r_redir_pend;
        w_pend_pc_next     = r_pend_pc;
        w_apply            = 1'b0;
        w_target           = r_fetch_pc;
`ifdef MISALIGN_TRAP_EN
        w_misalign_next    = r_misalign;
`endif

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                if (i_imem_ack) begin
                    if (r_redir_pend || i_redirect_valid) begin
                        // Returned word belongs to a stale path; refetch from newest target.
                        w_apply           = 1'b1;
                        w_target          = i_redirect_valid ? i_redirect_pc : r_pend_pc;
                        w_redir_pend_next = 1'b0;
                    end else begin
                        w_instr_next       = i_imem_rdata;
                        w_pc_next          = r_fetch_pc;
                        w_instr_valid_next = 1'b1;
                        w_state_next       = S_HOLD;
                    end
                end else if (i_redirect_valid) begin
                    w_redir_pend_next = 1'b1;
                    w_pend_pc_next    = i_redirect_pc;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_apply            = 1'b1;
                    w_target           = i_redirect_valid ? i_redirect_pc
                                                          : r_fetch_pc + 32'd4;
                    w_instr_valid_next = 1'b0;
                    w_instr_next       = NOP_INSTR;
                    w_state_next       = S_REQ;
                end
            end
            S_TRAP: begin
                w_state_next = S_TRAP;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_apply) begin
`ifdef MISALIGN_TRAP_EN
            if (w_target[1:0] != 2'b00) begin
                w_misalign_next = 1'b1;
                w_state_next    = S_TRAP;
            end else begin
                w_fetch_pc_next = w_target;
            end
`else
            w_fetch_pc_next = w_target & ~32'h0000_0003;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_redir_pend  <= 1'b0;
            r_pend_pc     <= RESET_PC;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_instr       <= w_instr_next;
            r_pc          <= w_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_redir_pend  <= w_redir_pend_next;
            r_pend_pc     <= w_pend_pc_next;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_next;
        end
    end

    assign o_misalign = r_misalign;
`else
    assign o_misalign = 1'b0;
`endif

    assign o_imem_req    = (r_state == S_REQ);
    assign o_imem_addr   = r_fetch_pc;
    assign o_instr       = r_instr;
    assign o_pc          = r_pc;
    assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized memory/stall/redirect
// traffic, all compared each cycle against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the fetch stage is doing, not how.
    bit          m_boot;
    bit          m_hold;
    bit          m_trap;
    bit          m_pend;
    logic [31:0] m_addr;
    logic [31:0] m_tgt;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .i_stall         (stall),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_instr         (instr),
        .o_pc            (pc),
        .o_instr_valid   (instr_valid),
        .o_misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_hold  = 1'b0;
        m_trap  = 1'b0;
        m_pend  = 1'b0;
        m_addr  = RESET_PC;
        m_tgt   = RESET_PC;
        m_instr = NOP;
        m_pc    = RESET_PC;
    endtask

    task automatic go_to(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        if (t % 4 != 0) m_trap = 1'b1;
        else            m_addr = t;
`else
        m_addr = t - (t % 4);
`endif
    endtask

    task automatic check_outputs();
        bit fetching;
        fetching = !m_boot && !m_hold && !m_trap;
        chk1("imem_req", imem_req, fetching);
        if (fetching) chk32("imem_addr", imem_addr, m_addr);
        chk1("instr_valid", instr_valid, m_hold);
        chk32("instr", instr, m_hold ? m_instr : NOP);
        chk32("pc", pc, m_pc);
        chk1("misalign", misalign, m_trap);
    endtask

    task automatic model_update(input bit ack, input logic [31:0] rdata, input bit stl,
                                input bit rv, input logic [31:0] rpc);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_trap) begin
            m_trap = 1'b1;
        end else if (m_hold) begin
            if (!stl) begin
                m_hold = 1'b0;
                go_to(rv ? rpc : m_addr + 32'd4);
            end
        end else if (ack) begin
            if (m_pend || rv) begin
                go_to(rv ? rpc : m_tgt);
                m_pend = 1'b0;
            end else begin
                m_hold  = 1'b1;
                m_instr = rdata;
                m_pc    = m_addr;
            end
        end else if (rv) begin
            m_pend = 1'b1;
            m_tgt  = rpc;
        end
    endtask

    task automatic cyc(input bit rst_v, input bit ack, input logic [31:0] rdata, input bit stl,
                       input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        rst_n          = rst_v;
        imem_ack       = ack;
        imem_rdata     = rdata;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (!rst_v) model_reset();
        check_outputs();
        if (rst_v) model_update(ack, rdata, stl, rv, rpc);
    endtask

    task automatic step(input bit ack, input logic [31:0] rdata, input bit stl, input bit rv,
                        input logic [31:0] rpc);
        cyc(1'b1, ack, rdata, stl, rv, rpc);
    endtask

    // Reset with ack held high so a late ack for the abandoned request is present.
    task automatic do_reset();
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Back-to-back fetch with zero wait states.
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h1111_0001, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        // Three wait states at 0x4, then ack.
        repeat (3) step(1'b0, 32'hBAD0_0004, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h2222_0004, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        // Redirect pulse during a wait-state request at 0x8; returned data dropped.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hBAD0_0008, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h3333_0200, 1'b0, 1'b0, 32'h0);
        // Stalled hold ignores redirect; accept with redirect to 0x100.
        repeat (5) step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 32'h4444_0100, 1'b0, 1'b0, 32'h0);
        // Wrap from the top word of the address space.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 32'h5555_FFFC, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'h0);
        // Misaligned redirect on accept.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
        step(1'b1, 32'h7777_0100, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0);

        // Randomized traffic, with resets landing mid-stream.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 800; i++) begin
                logic [31:0] rpc;
                rpc = $urandom;
                if ($urandom_range(0, 15) != 0) rpc = rpc & ~32'h3;
                step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0, rpc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
